// File: rtl/sprite_blitter.sv
// Sprite draw engine: copies a w x h sprite from a synchronous ROM into the
// frame controller's program-write port, one pixel per 2-cycle slot.
module sprite_blitter #(
  parameter logic [15:0] TRANSPARENT = 16'hF81F,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480
) (
  input  logic        sram_clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_x,
  input  logic [9:0]  cmd_y,
  input  logic [6:0]  cmd_w,
  input  logic [6:0]  cmd_h,
  input  logic [15:0] cmd_base,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic [9:0]  program_x,
  output logic [9:0]  program_y,
  output logic [15:0] program_data,
  output logic        program_write,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    FLUSH
  } state_t;

  localparam logic [10:0] SCREEN_W_L = 11'(SCREEN_W);
  localparam logic [10:0] SCREEN_H_L = 11'(SCREEN_H);

  state_t      state, state_next;
  logic        ph;
  logic [6:0]  cx, cy;
  logic [9:0]  x_r, y_r;
  logic [6:0]  w_r, h_r;
  logic        accept;
  logic        last_col, last_px;
  logic [10:0] sum_x, sum_y;
  logic        visible;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;

  assign last_col = (cx == w_r - 7'd1);
  assign last_px  = last_col && (cy == h_r - 7'd1);

  // 11-bit sums so positions past x=1023 / y=1023 never wrap back on screen
  assign sum_x   = {1'b0, x_r} + {4'b0, cx};
  assign sum_y   = {1'b0, y_r} + {4'b0, cy};
  assign visible = (rom_data != TRANSPARENT) && (sum_x < SCREEN_W_L) && (sum_y < SCREEN_H_L);

  always_ff @(posedge sram_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_w == 7'd0 || cmd_h == 7'd0) state_next = FLUSH;
          else                                state_next = DRAW;
        end
      end
      DRAW:    if (ph && last_px) state_next = FLUSH;
      FLUSH:   if (ph)            state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ph doubles as the FLUSH cycle counter; it is 0 on entry to FLUSH either way
  always_ff @(posedge sram_clk) begin
    if (reset) begin
      ph            <= 1'b0;
      cx            <= '0;
      cy            <= '0;
      x_r           <= '0;
      y_r           <= '0;
      w_r           <= '0;
      h_r           <= '0;
      rom_addr      <= '0;
      program_x     <= '0;
      program_y     <= '0;
      program_data  <= '0;
      program_write <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            x_r      <= cmd_x;
            y_r      <= cmd_y;
            w_r      <= cmd_w;
            h_r      <= cmd_h;
            rom_addr <= cmd_base;
            cx       <= '0;
            cy       <= '0;
            ph       <= 1'b0;
          end
        end
        DRAW: begin
          ph <= ~ph;
          if (ph) begin
            program_x     <= sum_x[9:0];
            program_y     <= sum_y[9:0];
            program_data  <= rom_data;
            program_write <= visible;
            rom_addr      <= rom_addr + 16'd1;
            if (last_col) begin
              cx <= '0;
              cy <= cy + 7'd1;
            end else begin
              cx <= cx + 7'd1;
            end
          end
        end
        FLUSH: begin
          ph <= ~ph;
          if (ph) begin
            program_write <= 1'b0;
            done          <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: directed command table, held-valid and mid-draw
// reset sequences, then random commands against a per-pixel reference model.
module tb_sprite_blitter;

  localparam logic [15:0] TR = 16'hF81F;

  logic        sram_clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x, cmd_y;
  logic [6:0]  cmd_w, cmd_h;
  logic [15:0] cmd_base;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic [9:0]  program_x, program_y;
  logic [15:0] program_data;
  logic        program_write;
  logic        busy;
  logic        done;

  sprite_blitter #(.TRANSPARENT(TR), .SCREEN_W(640), .SCREEN_H(480)) dut (
    .sram_clk(sram_clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_base(cmd_base),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .program_x(program_x), .program_y(program_y), .program_data(program_data),
    .program_write(program_write), .busy(busy), .done(done)
  );

  initial sram_clk = 1'b0;
  always #5 sram_clk = ~sram_clk;

  logic [15:0] rom_mem [0:65535];
  always @(posedge sram_clk) rom_data <= rom_mem[rom_addr];

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int x, y, w, h, base;
    int exp_writes;
    int exp_done;
  } cmd_t;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input int x, input int y, input int w, input int h,
                              input int base, input int wr, input int dn);
    cmd_t c;
    c.x = x; c.y = y; c.w = w; c.h = h; c.base = base;
    c.exp_writes = wr; c.exp_done = dn;
    return c;
  endfunction

  function automatic int model_writes(input cmd_t c);
    int cnt = 0;
    for (int k = 0; k < c.w * c.h; k++) begin
      if (rom_mem[(c.base + k) & 16'hFFFF] != TR &&
          c.x + k % c.w < 640 && c.y + k / c.w < 480) cnt++;
    end
    return cnt;
  endfunction

  task automatic poke(input int base, input int count);
    for (int i = 0; i < count; i++) rom_mem[(base + i) & 16'hFFFF] = 16'h0100 + 16'(i);
  endtask

  task automatic issue(input cmd_t c, input bit hold);
    @(negedge sram_clk);
    cmd_x = c.x[9:0]; cmd_y = c.y[9:0]; cmd_w = c.w[6:0]; cmd_h = c.h[6:0];
    cmd_base = c.base[15:0];
    cmd_valid = 1'b1;
    @(posedge sram_clk); #1;
    chk("accept_busy", busy, 1);
    chk("accept_rom_addr", rom_addr, c.base & 16'hFFFF);
    chk("accept_done", done, 0);
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Checks every edge after the accept edge up to the done edge (or stop_e).
  task automatic watch(input cmd_t c, input int stop_e, output int writes);
    int n = c.w * c.h;
    int k, px, py;
    bit exp_w;
    writes = 0;
    for (int e = 1; e <= c.exp_done && e <= stop_e; e++) begin
      @(posedge sram_clk); #1;
      chk("busy", busy, int'(e < c.exp_done));
      chk("cmd_ready", cmd_ready, int'(e >= c.exp_done));
      chk("done", done, int'(e == c.exp_done));
      if (n > 0 && e >= 2 && e <= 2 * n + 1) begin
        k  = (e - 2) / 2;
        px = c.x + k % c.w;
        py = c.y + k / c.w;
        exp_w = (rom_mem[(c.base + k) & 16'hFFFF] != TR) && px < 640 && py < 480;
        chk("program_x", program_x, px % 1024);
        chk("program_y", program_y, py % 1024);
        chk("program_data", program_data, rom_mem[(c.base + k) & 16'hFFFF]);
        chk("program_write", program_write, exp_w);
        if (e % 2 == 0 && program_write) writes++;
      end else begin
        chk("program_write_idle", program_write, 0);
      end
    end
    if (stop_e >= c.exp_done) chk("end_rom_addr", rom_addr, (c.base + n) & 16'hFFFF);
  endtask

  cmd_t tbl [9];

  initial begin
    cmd_t c, c2;
    int wr;

    for (int i = 0; i < 65536; i++)
      rom_mem[i] = ($urandom_range(0, 7) == 0) ? TR : 16'($urandom);
    poke(16'h0010, 4);
    rom_mem[16'h0010] = 16'hAAA1; rom_mem[16'h0011] = 16'hBBB2;
    rom_mem[16'h0012] = 16'hCCC3; rom_mem[16'h0013] = 16'hDDD4;
    poke(16'h0100, 3); rom_mem[16'h0101] = TR;
    poke(16'h0200, 8);
    poke(16'hFFFF, 3);
    poke(16'h0400, 4);
    poke(16'h0500, 3);
    poke(16'h0600, 64);
    poke(16'h0700, 2);
    poke(16'h0800, 1);

    tbl[0] = mk(100,  50,  2, 2, 16'h0010, 4,  10);
    tbl[1] = mk(200,  60,  3, 1, 16'h0100, 2,   8);
    tbl[2] = mk(638, 479,  4, 2, 16'h0200, 2,  18);
    tbl[3] = mk( 10,  10,  0, 5, 16'h0300, 0,   2);
    tbl[4] = mk( 10,  10,  3, 0, 16'h0300, 0,   2);
    tbl[5] = mk(  0,   0,  3, 1, 16'hFFFF, 3,   8);
    tbl[6] = mk(1022, 10,  4, 1, 16'h0400, 0,  10);
    tbl[7] = mk(  5, 478,  1, 3, 16'h0500, 2,   8);
    tbl[8] = mk(639,   0, 64, 1, 16'h0600, 1, 130);

    // reset with a command pending
    reset = 1'b1; cmd_valid = 1'b1;
    cmd_x = 10'd1; cmd_y = 10'd1; cmd_w = 7'd1; cmd_h = 7'd1; cmd_base = 16'h1234;
    repeat (3) @(posedge sram_clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_write", program_write, 0);
    chk("rst_x", program_x, 0);
    chk("rst_y", program_y, 0);
    chk("rst_data", program_data, 0);
    chk("rst_rom_addr", rom_addr, 0);
    @(negedge sram_clk);
    reset = 1'b0; cmd_valid = 1'b0;

    for (int i = 0; i < 9; i++) begin
      issue(tbl[i], 1'b0);
      watch(tbl[i], 1000, wr);
      chk("writes", wr, tbl[i].exp_writes);
    end

    // valid held through a draw: fields change mid-draw, second accept at E7
    c  = mk(20, 20, 2, 1, 16'h0700, 2, 6);
    c2 = mk(30, 30, 1, 1, 16'h0800, 1, 4);
    issue(c, 1'b1);
    cmd_x = 10'd30; cmd_y = 10'd30; cmd_w = 7'd1; cmd_h = 7'd1; cmd_base = 16'h0800;
    watch(c, 1000, wr);
    chk("held_writes1", wr, c.exp_writes);
    @(posedge sram_clk); #1;
    chk("held_accept_busy", busy, 1);
    chk("held_accept_rom_addr", rom_addr, 16'h0800);
    chk("held_accept_done", done, 0);
    cmd_valid = 1'b0;
    watch(c2, 1000, wr);
    chk("held_writes2", wr, c2.exp_writes);

    // reset while the 3rd pixel of an 8x8 sprite is held
    c = mk(50, 50, 8, 8, 16'h0900, 0, 130);
    issue(c, 1'b0);
    watch(c, 6, wr);
    @(negedge sram_clk);
    reset = 1'b1; cmd_valid = 1'b1;
    @(posedge sram_clk); #1;
    chk("mid_rst_write", program_write, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_rom_addr", rom_addr, 0);
    chk("mid_rst_x", program_x, 0);
    chk("mid_rst_done", done, 0);
    @(negedge sram_clk);
    reset = 1'b0; cmd_valid = 1'b0;
    @(posedge sram_clk); #1;
    chk("post_rst_busy", busy, 0);

    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = $urandom_range(0, 3);
      c.x = (sel == 0) ? $urandom_range(0, 1023) : (sel == 1) ? $urandom_range(620, 660) : $urandom_range(0, 600);
      sel = $urandom_range(0, 3);
      c.y = (sel == 0) ? $urandom_range(0, 1023) : (sel == 1) ? $urandom_range(470, 490) : $urandom_range(0, 460);
      c.w = $urandom_range(0, 9);
      c.h = $urandom_range(0, 9);
      c.base = $urandom_range(0, 65535);
      c.exp_done = (c.w * c.h > 0) ? 2 * c.w * c.h + 2 : 2;
      c.exp_writes = model_writes(c);
      issue(c, 1'b0);
      watch(c, 1000, wr);
      chk("rand_writes", wr, c.exp_writes);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Draw engine that copies a rectangular sprite from a synchronous sprite ROM into the hidden frame buffer through the program-write port of the SRAM frame controller. It accepts one draw command at a time and walks the sprite row-major, one pixel per 2-cycle slot. That matches the controller's program-write acceptance rate of one slot every two `sram_clk` cycles. Transparent pixels and off-screen pixels are suppressed, so the background already written by the controller is preserved.

## Interface
Parameters:
- `TRANSPARENT`, 16'hF81F: RGB565 colour key; ROM pixels equal to it are not written.
- `SCREEN_W`, 640: exclusive x clip bound.
- `SCREEN_H`, 480: exclusive y clip bound.

Ports:
- `sram_clk`  in  1  100 MHz clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high only in IDLE; command accepted on `cmd_valid && cmd_ready` at posedge.
- `cmd_x`  in  10  screen x of sprite top-left.
- `cmd_y`  in  10  screen y of sprite top-left.
- `cmd_w`  in  7  sprite width, 0..64.
- `cmd_h`  in  7  sprite height, 0..64.
- `cmd_base`  in  16  ROM address of the sprite's first pixel.
- `rom_addr`  out  16  registered sprite ROM address.
- `rom_data`  in  16  ROM pixel; valid one cycle after `rom_addr` changes.
- `program_x`  out  10  pixel x to controller.
- `program_y`  out  10  pixel y to controller.
- `program_data`  out  16  pixel colour to controller.
- `program_write`  out  1  write enable to controller.
- `busy`  out  1  high in DRAW and FLUSH.
- `done`  out  1  one-cycle pulse when a command completes.

## Operation
- States:
  - IDLE: `cmd_ready` = 1.
  - DRAW: slot phase bit `ph` toggles every cycle.
  - FLUSH: two cycles.
- On accept:
  - Latch x, y, w, h.
  - `rom_addr` <= `cmd_base`.
  - Column counter `cx` <= 0, row counter `cy` <= 0, `ph` <= 0.
  - Next state DRAW, or FLUSH if w == 0 or h == 0.
- DRAW, ph = 0: ROM sees `rom_addr`.
- DRAW, ph = 1: `rom_data` is valid. At the closing edge:
  - `program_x` <= x + cx, truncated to 10 bits.
  - `program_y` <= y + cy, truncated to 10 bits.
  - `program_data` <= `rom_data`.
  - `program_write` <= (`rom_data` != `TRANSPARENT`) && (x + cx < `SCREEN_W`) && (y + cy < `SCREEN_H`). Both sums are 11-bit; no wrap-around into visible area.
  - `rom_addr` <= `rom_addr` + 1 (mod 2^16).
  - cx <= cx + 1; at cx == w − 1: cx <= 0 and cy <= cy + 1.
  - Last pixel (cx == w − 1 and cy == h − 1): next state FLUSH.
- Write outputs change only at the closing edge of a ph = 1 cycle, so each pixel is held exactly 2 cycles. The controller therefore samples it exactly once, whatever its stage alignment.
- FLUSH: hold the last pixel for 2 cycles. At the second edge:
  - `program_write` <= 0, `done` <= 1.
  - Next state IDLE.
- `cmd_*` is ignored while busy.
- The upstream scheduler must finish all draws for a frame before the controller's frame toggle. The blitter has no frame awareness.

## Timing
- Accept at edge E0. First pixel is visible on `program_*` after edge E2.
- Pixel k (0-based) is registered at edge E(2k+2).
- For n = w·h > 0: `program_write` clears and `done` rises at edge E(2n+2). `cmd_ready` = 1 in that same following cycle.
- Earliest back-to-back accept: edge E(2n+3).
- Zero-size command: `done` at edge E2, no writes.
- Reset values, taking effect at the next posedge, including mid-draw:
  - state IDLE, `cmd_ready` 1, `busy` 0, `done` 0.
  - `program_write` 0; `program_x`, `program_y`, `program_data` 0.
  - `rom_addr` 0; cx, cy, ph 0.
- A pending `cmd_valid` in the reset cycle is not accepted.

## Test plan
- 2×2 sprite at (100, 50), base 0x0010, ROM values A, B, C, D (none transparent) → writes (100,50)=A, (101,50)=B, (100,51)=C, (101,51)=D. Each held 2 cycles; `done` at E10.
- 3×1 sprite whose middle pixel is 16'hF81F → `program_write` low only during the second pixel's hold window. x advances 0, 1, 2 regardless.
- Sprite at (638, 479), 4×2 → only (638,479) and (639,479) written. Other six slots have `program_write` = 0; `done` timing unchanged (E18).
- w = 0, h = 5 → no writes; `done` pulse at E2; `busy` high for 2 cycles.
- Assert reset during the 3rd pixel of an 8×8 draw → next cycle `program_write` = 0, `busy` = 0, `cmd_ready` = 1, `rom_addr` = 0.
- `cmd_valid` held high through a draw, with a second command → second command accepted only at E(2n+3). A `rom_addr` wrap from base 0xFFFF continues at 0x0000.
